// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the two-requester RAM controller.
// Contents:
//   state_t                        - controller FSM encoding (IDLE/ACCESS/WAIT/RESP)
//   REQ_M0 / REQ_M1                - requester identifiers (instruction fetch / load-store)
//   DEF_ADDR_WIDTH, DEF_DATA_WIDTH - default memory_ram geometry
package ram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 32;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter with a last-grant pointer.
// Ports:
//   i_clk, i_rst_n   - clock, synchronous active-low reset
//   i_req0, i_req1   - requests from M0 / M1
//   i_en             - arbitration allowed this cycle (controller idle)
//   o_gnt            - one-hot combinational grant {M1, M0}; zero when disabled
// A tie goes to the requester not granted last (or always to M1 when
// FIXED_PRIO is set). The pointer only moves when a grant is issued.
module rr_arbiter2
    import ram_ctrl_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_en,
    output logic [1:0] o_gnt
);

    logic r_last;
    logic w_tie_m1;

    always_comb begin
        w_tie_m1 = FIXED_PRIO ? 1'b1 : (r_last == REQ_M0);
        o_gnt    = 2'b00;
        if (i_en) begin
            if (i_req0 && i_req1) begin
                o_gnt = w_tie_m1 ? 2'b10 : 2'b01;
            end else begin
                o_gnt = {i_req1, i_req0};
            end
        end
    end

    // Reset points at M1 so that M0 wins the first tie.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last <= REQ_M1;
        end else if (o_gnt != 2'b00) begin
            r_last <= o_gnt[1];
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester controller for the single-port memory_ram.
// M0 is the instruction-fetch port, M1 the load/store port. One access is
// in flight at a time: IDLE grants and latches, ACCESS drives the RAM
// strobes for one cycle, WAIT covers the RAM read latency, RESP returns the
// read data to the requester that owns the access. All outputs registered.
// Ports:
//   iCLK, iRST_N                     - clock, synchronous active-low reset
//   iMx_REQ/WE/ADDR/WDATA            - requester x access request (x = 0, 1)
//   oMx_GNT                          - 1-cycle pulse, request accepted
//   oMx_RVALID, oMx_RDATA            - 1-cycle read-data valid, read data
//   oRAM_CE/RD/WR/ADDR/DATA          - memory_ram control, address, write data
//   iRAM_DATA                        - memory_ram read data
module ram_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RD_LATENCY = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic                  iM0_REQ,
    input  logic                  iM0_WE,
    input  logic [ADDR_WIDTH-1:0] iM0_ADDR,
    input  logic [DATA_WIDTH-1:0] iM0_WDATA,
    output logic                  oM0_GNT,
    output logic                  oM0_RVALID,
    output logic [DATA_WIDTH-1:0] oM0_RDATA,
    input  logic                  iM1_REQ,
    input  logic                  iM1_WE,
    input  logic [ADDR_WIDTH-1:0] iM1_ADDR,
    input  logic [DATA_WIDTH-1:0] iM1_WDATA,
    output logic                  oM1_GNT,
    output logic                  oM1_RVALID,
    output logic [DATA_WIDTH-1:0] oM1_RDATA,
    output logic                  oRAM_CE,
    output logic                  oRAM_RD,
    output logic                  oRAM_WR,
    output logic [ADDR_WIDTH-1:0] oRAM_ADDR,
    output logic [DATA_WIDTH-1:0] oRAM_DATA,
    input  logic [DATA_WIDTH-1:0] iRAM_DATA
);

    // RD_LATENCY is at most 4, so the WAIT counter never exceeds 3.
    localparam int                CNT_W    = 2;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(RD_LATENCY - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_owner;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [CNT_W-1:0]      r_cnt;
    logic [1:0]            w_gnt;
    logic                  w_idle;

    assign w_idle = (r_state == ST_IDLE);

    rr_arbiter2 #(
        .FIXED_PRIO (FIXED_PRIO != 0)
    ) u_arb (
        .i_clk   (iCLK),
        .i_rst_n (iRST_N),
        .i_req0  (iM0_REQ),
        .i_req1  (iM1_REQ),
        .i_en    (w_idle),
        .o_gnt   (w_gnt)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_gnt != 2'b00) w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = r_we ? ST_IDLE : ST_WAIT;
            ST_WAIT:   if (r_cnt == '0) w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_state    <= ST_IDLE;
            r_owner    <= REQ_M0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            oM0_GNT    <= 1'b0;
            oM1_GNT    <= 1'b0;
            oM0_RVALID <= 1'b0;
            oM1_RVALID <= 1'b0;
            oM0_RDATA  <= '0;
            oM1_RDATA  <= '0;
            oRAM_CE    <= 1'b0;
            oRAM_RD    <= 1'b0;
            oRAM_WR    <= 1'b0;
            oRAM_ADDR  <= '0;
            oRAM_DATA  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            // Grants are only non-zero in IDLE, so GNT is a single pulse.
            oM0_GNT    <= w_gnt[0];
            oM1_GNT    <= w_gnt[1];
            oM0_RVALID <= 1'b0;
            oM1_RVALID <= 1'b0;
            oRAM_RD    <= 1'b0;
            oRAM_WR    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt != 2'b00) begin
                        r_owner <= w_gnt[1];
                        r_we    <= w_gnt[1] ? iM1_WE    : iM0_WE;
                        r_addr  <= w_gnt[1] ? iM1_ADDR  : iM0_ADDR;
                        r_wdata <= w_gnt[1] ? iM1_WDATA : iM0_WDATA;
                    end
                end
                ST_ACCESS: begin
                    // CE and ADDR are left holding after this cycle.
                    oRAM_CE   <= 1'b1;
                    oRAM_ADDR <= r_addr;
                    oRAM_DATA <= r_wdata;
                    oRAM_WR   <= r_we;
                    oRAM_RD   <= !r_we;
                    r_cnt     <= CNT_LOAD;
                end
                ST_WAIT: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                ST_RESP: begin
                    if (r_owner == REQ_M1) begin
                        oM1_RDATA  <= iRAM_DATA;
                        oM1_RVALID <= 1'b1;
                    end else begin
                        oM0_RDATA  <= iRAM_DATA;
                        oM0_RVALID <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter. Three instances share one set of requester inputs:
// [0] round-robin, RD_LATENCY=1; [1] FIXED_PRIO=1, RD_LATENCY=1;
// [2] round-robin, RD_LATENCY=3. Each has its own behavioural memory_ram.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [7:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;

    logic [2:0]       m0_gnt, m1_gnt, m0_rv, m1_rv, ram_ce, ram_rd, ram_wr;
    logic [2:0][7:0]  ram_addr;
    logic [2:0][31:0] ram_wdat, ram_q, m0_rdata, m1_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 2) ? 3 : 1;
        logic [31:0] mem  [256];
        logic [31:0] pipe [LAT];

        ram_arbiter #(
            .ADDR_WIDTH (8),
            .DATA_WIDTH (32),
            .RD_LATENCY (LAT),
            .FIXED_PRIO ((g == 1) ? 1 : 0)
        ) u_dut (
            .iCLK       (clk),
            .iRST_N     (rst_n),
            .iM0_REQ    (m0_req),
            .iM0_WE     (m0_we),
            .iM0_ADDR   (m0_addr),
            .iM0_WDATA  (m0_wdata),
            .oM0_GNT    (m0_gnt[g]),
            .oM0_RVALID (m0_rv[g]),
            .oM0_RDATA  (m0_rdata[g]),
            .iM1_REQ    (m1_req),
            .iM1_WE     (m1_we),
            .iM1_ADDR   (m1_addr),
            .iM1_WDATA  (m1_wdata),
            .oM1_GNT    (m1_gnt[g]),
            .oM1_RVALID (m1_rv[g]),
            .oM1_RDATA  (m1_rdata[g]),
            .oRAM_CE    (ram_ce[g]),
            .oRAM_RD    (ram_rd[g]),
            .oRAM_WR    (ram_wr[g]),
            .oRAM_ADDR  (ram_addr[g]),
            .oRAM_DATA  (ram_wdat[g]),
            .iRAM_DATA  (ram_q[g])
        );

        // Read data is valid for exactly one cycle, LAT cycles after the strobe.
        always_ff @(posedge clk) begin
            if (ram_ce[g] && ram_wr[g]) mem[ram_addr[g]] <= ram_wdat[g];
            pipe[0] <= (ram_ce[g] && ram_rd[g]) ? mem[ram_addr[g]] : 32'hBAD0_0BAD;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign ram_q[g] = pipe[LAT-1];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        sb.delete();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic preload(input int s, input logic port, input logic [7:0] addr,
                           input logic [31:0] data);
        bit got = 0;
        idle_inputs();
        if (port) begin m1_req = 1; m1_we = 1; m1_addr = addr; m1_wdata = data; end
        else      begin m0_req = 1; m0_we = 1; m0_addr = addr; m0_wdata = data; end
        for (int t = 0; t < 10 && !got; t++) begin
            tick();
            if ((port ? m1_gnt[s] : m0_gnt[s]) === 1'b1) got = 1;
        end
        idle_inputs();
        tick();
        tick();
        n_checks++;
        if (!got) $display("FAIL preload_gnt: no grant for addr %h (port %0d)", addr, port);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 0;
        m0_req = 1; m1_req = 1;
        tick();
        tick();
        n_checks++;
        if ({m0_gnt, m1_gnt, m0_rv, m1_rv, ram_ce, ram_rd, ram_wr} !== '0)
            $display("FAIL reset_ctrl: got %h want 0",
                     {m0_gnt, m1_gnt, m0_rv, m1_rv, ram_ce, ram_rd, ram_wr});
        else n_pass++;
        n_checks++;
        if ({ram_addr, ram_wdat} !== '0) $display("FAIL reset_ram_bus: got %h want 0", {ram_addr, ram_wdat});
        else n_pass++;
        n_checks++;
        if ({m0_rdata, m1_rdata} !== '0) $display("FAIL reset_rdata: got %h want 0", {m0_rdata, m1_rdata});
        else n_pass++;
        idle_inputs();
        rst_n = 1;
        tick();
        n_checks++;
        if ({m0_gnt, m1_gnt} !== '0) $display("FAIL reset_no_req_gnt: got %b want 0", {m0_gnt, m1_gnt});
        else n_pass++;
    endtask

    task automatic test_write();
        int rv_cnt = 0;
        apply_reset();
        m0_req = 1; m0_we = 1; m0_addr = 8'h05; m0_wdata = 32'h1234_5678;
        tick();
        n_checks++;
        if ({m1_gnt[0], m0_gnt[0]} !== 2'b01) $display("FAIL write_gnt: got %b want 01", {m1_gnt[0], m0_gnt[0]});
        else n_pass++;
        n_checks++;
        if (ram_wr[0] !== 1'b0) $display("FAIL write_early_strobe: got %b want 0", ram_wr[0]);
        else n_pass++;
        idle_inputs();
        tick();
        n_checks++;
        if ({ram_ce[0], ram_wr[0], ram_rd[0], ram_addr[0], ram_wdat[0]} !== {3'b110, 8'h05, 32'h1234_5678})
            $display("FAIL write_strobe: ce/wr/rd %b%b%b addr %h data %h, want 110 05 12345678",
                     ram_ce[0], ram_wr[0], ram_rd[0], ram_addr[0], ram_wdat[0]);
        else n_pass++;
        n_checks++;
        if (m0_gnt[0] !== 1'b0) $display("FAIL write_gnt_pulse: got %b want 0", m0_gnt[0]);
        else n_pass++;
        for (int t = 0; t < 4; t++) begin
            if (m0_rv[0] || m1_rv[0]) rv_cnt++;
            tick();
        end
        n_checks++;
        if ({ram_ce[0], ram_wr[0], ram_addr[0]} !== {2'b10, 8'h05})
            $display("FAIL write_hold: ce/wr %b%b addr %h, want 10 05", ram_ce[0], ram_wr[0], ram_addr[0]);
        else n_pass++;
        n_checks++;
        if (rv_cnt != 0) $display("FAIL write_no_rvalid: got %0d pulses want 0", rv_cnt);
        else n_pass++;
    endtask

    task automatic test_read();
        int rd_at = -1, rd_cnt = 0, rv_at = -1;
        exp_t e;
        logic [1:0]  got_v;
        logic [31:0] got_d;
        m0_req = 1; m0_we = 0; m0_addr = 8'h05;
        tick();
        n_checks++;
        if (m0_gnt[0] !== 1'b1) $display("FAIL read_gnt: got %b want 1", m0_gnt[0]);
        else n_pass++;
        sb.push_back('{1'b0, 32'h1234_5678});
        idle_inputs();
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (ram_rd[0]) begin rd_cnt++; if (rd_at < 0) rd_at = t; end
            if (m0_rv[0] || m1_rv[0]) begin
                if (rv_at < 0) rv_at = t;
                n_checks++;
                if (sb.size() == 0) $display("FAIL read_resp: unexpected rvalid m0=%b m1=%b", m0_rv[0], m1_rv[0]);
                else begin
                    e = sb.pop_front();
                    got_v = {m1_rv[0], m0_rv[0]};
                    got_d = e.port ? m1_rdata[0] : m0_rdata[0];
                    if (got_v !== (e.port ? 2'b10 : 2'b01) || got_d !== e.data)
                        $display("FAIL read_resp: rvalid %b data %h, want port %0d data %h", got_v, got_d, e.port, e.data);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if (rd_at != 1 || rd_cnt != 1) $display("FAIL read_strobe: at %0d count %0d, want at 1 count 1", rd_at, rd_cnt);
        else n_pass++;
        n_checks++;
        if (rv_at != 3) $display("FAIL read_latency: rvalid at %0d want 3", rv_at);
        else n_pass++;
        n_checks++;
        if (sb.size() != 0) $display("FAIL read_drain: %0d responses missing", sb.size());
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int order[$];
        exp_t e;
        logic [1:0]  got_v;
        logic [31:0] got_d;
        preload(0, 1'b0, 8'h01, 32'h1111_1111);
        preload(0, 1'b1, 8'h02, 32'h2222_2222);
        apply_reset();
        m0_req = 1; m0_we = 0; m0_addr = 8'h01;
        m1_req = 1; m1_we = 0; m1_addr = 8'h02;
        for (int t = 0; t < 60; t++) begin
            tick();
            if (m0_gnt[0]) begin order.push_back(0); sb.push_back('{1'b0, 32'h1111_1111}); end
            if (m1_gnt[0]) begin order.push_back(1); sb.push_back('{1'b1, 32'h2222_2222}); end
            if (order.size() >= 4) begin m0_req = 0; m1_req = 0; end
            if (m0_rv[0] || m1_rv[0]) begin
                n_checks++;
                if (sb.size() == 0) $display("FAIL rr_resp: unexpected rvalid m0=%b m1=%b", m0_rv[0], m1_rv[0]);
                else begin
                    e = sb.pop_front();
                    got_v = {m1_rv[0], m0_rv[0]};
                    got_d = e.port ? m1_rdata[0] : m0_rdata[0];
                    if (got_v !== (e.port ? 2'b10 : 2'b01) || got_d !== e.data)
                        $display("FAIL rr_resp: rvalid %b data %h, want port %0d data %h", got_v, got_d, e.port, e.data);
                    else n_pass++;
                end
            end
            if (order.size() >= 4 && sb.size() == 0) break;
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= order.size()) $display("FAIL rr_order[%0d]: no grant want M%0d", i, i % 2);
            else if (order[i] != i % 2) $display("FAIL rr_order[%0d]: got M%0d want M%0d", i, order[i], i % 2);
            else n_pass++;
        end
        n_checks++;
        if (sb.size() != 0 || order.size() != 4)
            $display("FAIL rr_drain: %0d grants, %0d responses missing; want 4, 0", order.size(), sb.size());
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_fixed_prio();
        int order[$];
        int m1_cnt = 0;
        exp_t e;
        logic [1:0]  got_v;
        logic [31:0] got_d;
        apply_reset();
        m0_req = 1; m0_we = 0; m0_addr = 8'h01;
        m1_req = 1; m1_we = 0; m1_addr = 8'h02;
        for (int t = 0; t < 80; t++) begin
            tick();
            if (m0_gnt[1]) begin order.push_back(0); sb.push_back('{1'b0, 32'h1111_1111}); m0_req = 0; end
            if (m1_gnt[1]) begin
                order.push_back(1); sb.push_back('{1'b1, 32'h2222_2222});
                m1_cnt++;
                if (m1_cnt >= 3) m1_req = 0;
            end
            if (m0_rv[1] || m1_rv[1]) begin
                n_checks++;
                if (sb.size() == 0) $display("FAIL fp_resp: unexpected rvalid m0=%b m1=%b", m0_rv[1], m1_rv[1]);
                else begin
                    e = sb.pop_front();
                    got_v = {m1_rv[1], m0_rv[1]};
                    got_d = e.port ? m1_rdata[1] : m0_rdata[1];
                    if (got_v !== (e.port ? 2'b10 : 2'b01) || got_d !== e.data)
                        $display("FAIL fp_resp: rvalid %b data %h, want port %0d data %h", got_v, got_d, e.port, e.data);
                    else n_pass++;
                end
            end
            if (order.size() >= 4 && sb.size() == 0) break;
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= order.size()) $display("FAIL fp_order[%0d]: no grant want M%0d", i, (i < 3) ? 1 : 0);
            else if (order[i] != ((i < 3) ? 1 : 0))
                $display("FAIL fp_order[%0d]: got M%0d want M%0d", i, order[i], (i < 3) ? 1 : 0);
            else n_pass++;
        end
        n_checks++;
        if (sb.size() != 0 || order.size() != 4)
            $display("FAIL fp_drain: %0d grants, %0d responses missing; want 4, 0", order.size(), sb.size());
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        exp_t e;
        logic [1:0]  got_v;
        logic [31:0] got_d;
        apply_reset();
        m1_req = 1; m1_we = 0; m1_addr = 8'h02;
        tick();
        n_checks++;
        if (m1_gnt[0] !== 1'b1) $display("FAIL rmid_gnt: got %b want 1", m1_gnt[0]);
        else n_pass++;
        idle_inputs();
        tick();
        n_checks++;
        if (ram_rd[0] !== 1'b1) $display("FAIL rmid_strobe: got %b want 1", ram_rd[0]);
        else n_pass++;
        rst_n = 0;
        tick();
        n_checks++;
        if ({m0_gnt[0], m1_gnt[0], m0_rv[0], m1_rv[0], ram_ce[0], ram_rd[0], ram_wr[0], ram_addr[0], ram_wdat[0]} !== '0)
            $display("FAIL rmid_outputs: ctrl %b%b%b%b%b%b%b addr %h data %h want all 0",
                     m0_gnt[0], m1_gnt[0], m0_rv[0], m1_rv[0], ram_ce[0], ram_rd[0], ram_wr[0], ram_addr[0], ram_wdat[0]);
        else n_pass++;
        n_checks++;
        if ({m0_rdata[0], m1_rdata[0]} !== '0) $display("FAIL rmid_rdata: got %h want 0", {m0_rdata[0], m1_rdata[0]});
        else n_pass++;
        rst_n = 1;
        for (int t = 0; t < 4; t++) begin
            tick();
            if (m0_rv[0] || m1_rv[0] || m0_gnt[0] || m1_gnt[0] || ram_rd[0]) stray++;
        end
        n_checks++;
        if (stray != 0) $display("FAIL rmid_abandon: %0d stray events want 0", stray);
        else n_pass++;
        m0_req = 1; m0_we = 0; m0_addr = 8'h01;
        m1_req = 1; m1_we = 0; m1_addr = 8'h02;
        tick();
        n_checks++;
        if ({m1_gnt[0], m0_gnt[0]} !== 2'b01) $display("FAIL rmid_first_tie: got %b want 01", {m1_gnt[0], m0_gnt[0]});
        else n_pass++;
        idle_inputs();
        sb.push_back('{1'b0, 32'h1111_1111});
        for (int t = 0; t < 8; t++) begin
            tick();
            if (m0_rv[0] || m1_rv[0]) begin
                n_checks++;
                if (sb.size() == 0) $display("FAIL rmid_resp: unexpected rvalid m0=%b m1=%b", m0_rv[0], m1_rv[0]);
                else begin
                    e = sb.pop_front();
                    got_v = {m1_rv[0], m0_rv[0]};
                    got_d = e.port ? m1_rdata[0] : m0_rdata[0];
                    if (got_v !== (e.port ? 2'b10 : 2'b01) || got_d !== e.data)
                        $display("FAIL rmid_resp: rvalid %b data %h, want port %0d data %h", got_v, got_d, e.port, e.data);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if (sb.size() != 0) $display("FAIL rmid_drain: %0d responses missing", sb.size());
        else n_pass++;
    endtask

    task automatic test_latency3();
        int g0_at = -1, g1_cnt = 0, rv1_at = -1;
        exp_t e;
        logic [1:0]  got_v;
        logic [31:0] got_d;
        apply_reset();
        preload(2, 1'b0, 8'h0A, 32'hDEAD_BEEF);
        m1_req = 1; m1_we = 0; m1_addr = 8'h0A;
        tick();
        n_checks++;
        if (m1_gnt[2] !== 1'b1) $display("FAIL lat3_gnt: got %b want 1", m1_gnt[2]);
        else n_pass++;
        sb.push_back('{1'b1, 32'hDEAD_BEEF});
        idle_inputs();
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (m0_gnt[2]) begin
                if (g0_at < 0) g0_at = t;
                m0_req = 0;
                sb.push_back('{1'b0, 32'h1111_1111});
            end
            if (m1_gnt[2]) g1_cnt++;
            if (m0_rv[2] || m1_rv[2]) begin
                if (m1_rv[2] && rv1_at < 0) rv1_at = t;
                n_checks++;
                if (sb.size() == 0) $display("FAIL lat3_resp: unexpected rvalid m0=%b m1=%b", m0_rv[2], m1_rv[2]);
                else begin
                    e = sb.pop_front();
                    got_v = {m1_rv[2], m0_rv[2]};
                    got_d = e.port ? m1_rdata[2] : m0_rdata[2];
                    if (got_v !== (e.port ? 2'b10 : 2'b01) || got_d !== e.data)
                        $display("FAIL lat3_resp: rvalid %b data %h, want port %0d data %h", got_v, got_d, e.port, e.data);
                    else n_pass++;
                end
            end
            // M0 asks mid-read; M1 asks briefly and withdraws before any IDLE.
            if (t == 1) begin
                m0_req = 1; m0_we = 0; m0_addr = 8'h01;
                m1_req = 1; m1_we = 0; m1_addr = 8'h02;
            end
            if (t == 2) m1_req = 0;
        end
        n_checks++;
        if (rv1_at != 5) $display("FAIL lat3_latency: rvalid at %0d want 5", rv1_at);
        else n_pass++;
        n_checks++;
        if (g0_at != 6) $display("FAIL lat3_pending_gnt: M0 granted at %0d want 6", g0_at);
        else n_pass++;
        n_checks++;
        if (g1_cnt != 0) $display("FAIL lat3_dropped_req: M1 granted %0d times want 0", g1_cnt);
        else n_pass++;
        n_checks++;
        if (sb.size() != 0) $display("FAIL lat3_drain: %0d responses missing", sb.size());
        else n_pass++;
        idle_inputs();
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_fixed_prio();
        test_reset_mid();
        test_latency3();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester controller for the single-port memory_ram (8-bit word address, 32-bit data, CE/RD/WR strobes).
- Requester M0 is the instruction-fetch port; requester M1 is the load/store port.
- Arbitrates between them, sequences each RAM access through a small FSM, and returns read data with a valid pulse.
- Sits between the core's fetch/LSU and memory_ram in the SoC.

Parameters:
- ADDR_WIDTH, 8, RAM word address width.
- DATA_WIDTH, 32, RAM data width.
- RD_LATENCY, 1, cycles from the RAM read strobe until iRAM_DATA is valid. Legal range 1..4.
- FIXED_PRIO, 0. 0 = round-robin; 1 = M1 always wins on a tie.

Ports:
- iCLK  in  1  system clock; all state updates on rising edge.
- iRST_N  in  1  synchronous, active-low reset.
- iM0_REQ  in  1  M0 access request; level, held until grant.
- iM0_WE  in  1  M0 write enable (1 = write, 0 = read).
- iM0_ADDR  in  ADDR_WIDTH  M0 word address.
- iM0_WDATA  in  DATA_WIDTH  M0 write data.
- oM0_GNT  out  1  one-cycle pulse: M0 request accepted, inputs captured.
- oM0_RVALID  out  1  one-cycle pulse: oM0_RDATA valid.
- oM0_RDATA  out  DATA_WIDTH  M0 read data.
- iM1_REQ, iM1_WE, iM1_ADDR, iM1_WDATA, oM1_GNT, oM1_RVALID, oM1_RDATA: same as the M0 ports, for M1.
- oRAM_CE  out  1  RAM chip enable.
- oRAM_RD  out  1  RAM read strobe.
- oRAM_WR  out  1  RAM write strobe.
- oRAM_ADDR  out  ADDR_WIDTH  RAM address.
- oRAM_DATA  out  DATA_WIDTH  RAM write data.
- iRAM_DATA  in  DATA_WIDTH  RAM read data.

Behaviour:
- Reset (iRST_N = 0 at a clock edge):
  - All outputs go to 0 and the FSM goes to IDLE.
  - The last-grant pointer is set to M1, so M0 wins the first tie.
  - Reset applies in any state: an in-flight access is abandoned, with no GNT, no RVALID and no RAM strobe on the next cycle.
- States: IDLE, ACCESS, WAIT, RESP. All outputs are registered.
- IDLE:
  - Any REQ high selects a winner; the FSM moves to ACCESS next cycle.
  - The winner's oMx_GNT pulses for exactly one cycle, in the cycle following the edge where the request was sampled.
  - ADDR, WE and WDATA are latched at that same edge.
- Arbitration:
  - Round-robin: on a tie, the requester not granted last wins; the pointer updates only on grant.
  - FIXED_PRIO = 1: M1 wins every tie.
  - A single requester always wins.
- ACCESS (exactly 1 cycle):
  - oRAM_CE = 1, oRAM_ADDR and oRAM_DATA from the latch, and oRAM_WR = WE or oRAM_RD = !WE.
  - Write: go to IDLE.
  - Read: go to WAIT with the latency counter loaded to RD_LATENCY-1.
  - RAM strobes are 0 in every other state; CE and ADDR hold their last value after the access.
- WAIT:
  - The counter decrements each cycle; at 0 the FSM goes to RESP.
  - With RD_LATENCY = 1, WAIT lasts 1 cycle.
- RESP:
  - iRAM_DATA is captured into the winner's oMx_RDATA, and oMx_RVALID pulses 1 cycle.
  - The non-winner's RDATA is unchanged.
  - The FSM returns to IDLE.
- Latency from GNT:
  - Write: strobe 1 cycle after GNT.
  - Read: RVALID RD_LATENCY+2 cycles after GNT.
- Requests arriving outside IDLE are held pending and are not granted until IDLE.
- A REQ dropped before its grant is ignored, with no side effect.
- No pipelining: at most one access is in flight.
- A requester may keep REQ high after GNT; that is treated as a new request in the next IDLE.
- Back-to-back requests from both masters alternate in round-robin mode.
- Address and data pass through unmodified; there is no width conversion.

Decomposition:
- ram_ctrl_pkg holds:
  - FSM state encoding (2-bit: IDLE=0, ACCESS=1, WAIT=2, RESP=3).
  - Requester ID constants (M0=0, M1=1).
  - Default ADDR_WIDTH / DATA_WIDTH.
- Sub-module rr_arbiter2:
  - Inputs: two requests, enable, FIXED_PRIO.
  - Outputs: one-hot grant; owns the last-grant pointer.
- ram_arbiter instantiates rr_arbiter2 and memory_ram-facing logic only; memory_ram itself is instantiated outside.

Test Plan:
1. Reset, then M0 write ADDR=0x05, WDATA=0x1234_5678 -> oM0_GNT pulse, next cycle oRAM_WR=1, CE=1, ADDR=0x05, DATA=0x12345678; no RVALID.
2. M0 read ADDR=0x05 (RD_LATENCY=1, behavioural RAM model) -> RD strobe 1 cycle after GNT, oM0_RVALID 3 cycles after GNT with oM0_RDATA=0x12345678; oM1_RVALID stays 0.
3. Both REQ high continuously after reset, reads to 0x01 (M0) and 0x02 (M1) -> grant order M0, M1, M0, M1; each RVALID goes to the matching port with the matching data.
4. FIXED_PRIO=1, both REQ high -> M1 granted every time; M0 granted only after M1 drops REQ.
5. iRST_N low during WAIT of an M1 read -> next cycle all outputs 0, no RVALID; after release, M0 wins the first tie.
6. RD_LATENCY=3, M1 read of 0x0A preloaded with 0xDEAD_BEEF -> RVALID 5 cycles after GNT with 0xDEADBEEF; M0 request raised mid-read is granted only after RESP.
